// File: rtl/mux_5bit.sv
// rtl/mux_5bit.sv - registered 2:1 selector for register-index fields (optional MUX_5_BIT_PARITY_EN adds out_parity)
module mux_5bit #(
  parameter int N_BIT = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_control,
  input  logic [N_BIT-1:0] in_0,
  input  logic [N_BIT-1:0] in_1,
  input  logic             in_valid,
  output logic [N_BIT-1:0] out_result,
  output logic             out_valid
`ifdef MUX_5_BIT_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  logic [N_BIT-1:0] sel_data;

  // Only a definite 1 picks in_1; an unknown select falls back to in_0 instead of smearing X.
  always_comb begin
    sel_data = in_0;
    if (in_control === 1'b1) begin
      sel_data = in_1;
    end
  end

  // Capture on accepted cycles; data holds on idle cycles while valid drops for one-cycle pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_result <= '0;
      out_valid  <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_result <= sel_data;
      end
    end
  end

`ifdef MUX_5_BIT_PARITY_EN
  // Parity is registered with the data so it always describes the value on out_result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_parity <= 1'b0;
    end else if (in_valid) begin
      out_parity <= ^sel_data;
    end
  end
`endif

endmodule

// File: tb/tb_mux_5bit.sv
// tb/tb_mux_5bit.sv - directed self-checking bench for mux_5bit
`timescale 1ns/1ps
module tb_mux_5bit;

  logic       clk;
  logic       rst_n;
  logic       in_control;
  logic [4:0] in_0;
  logic [4:0] in_1;
  logic       in_valid;
  logic [4:0] out_result;
  logic       out_valid;
`ifdef MUX_5_BIT_PARITY_EN
  logic       out_parity;
`endif

  int n_compared;
  int n_mismatched;

  mux_5bit #(.N_BIT(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_control (in_control),
    .in_0       (in_0),
    .in_1       (in_1),
    .in_valid   (in_valid),
    .out_result (out_result),
    .out_valid  (out_valid)
`ifdef MUX_5_BIT_PARITY_EN
    ,
    .out_parity (out_parity)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 ns past it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_control = 1'b1; in_0 = 5'h0A; in_1 = 5'h0B;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_compared++;
      if (out_result !== 5'h00) begin
        n_mismatched++;
        $display("FAIL reset_result[%0d]: got %h expected 00", i, out_result);
      end
      n_compared++;
      if (out_valid !== 1'b0) begin
        n_mismatched++;
        $display("FAIL reset_valid[%0d]: got %b expected 0", i, out_valid);
      end
`ifdef MUX_5_BIT_PARITY_EN
      n_compared++;
      if (out_parity !== 1'b0) begin
        n_mismatched++;
        $display("FAIL reset_parity[%0d]: got %b expected 0", i, out_parity);
      end
`endif
    end
    rst_n = 1'b1;
  endtask

  task automatic test_select();
    logic [4:0] exp_tab [2];
    exp_tab[0] = 5'h0A;
    exp_tab[1] = 5'h0B;
    in_valid = 1'b1; in_0 = 5'h0A; in_1 = 5'h0B;
    for (int i = 0; i < 2; i++) begin
      in_control = (i == 1);
      tick();
      n_compared++;
      if (out_result !== exp_tab[i]) begin
        n_mismatched++;
        $display("FAIL select_result[%0d]: got %h expected %h", i, out_result, exp_tab[i]);
      end
      n_compared++;
      if (out_valid !== 1'b1) begin
        n_mismatched++;
        $display("FAIL select_valid[%0d]: got %b expected 1", i, out_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1; in_control = 1'b0; in_0 = 5'h01; in_1 = 5'h02;
    tick();
    n_compared++;
    if (out_result !== 5'h01) begin
      n_mismatched++;
      $display("FAIL b2b_first: got %h expected 01", out_result);
    end
    in_control = 1'b1; in_0 = 5'h03; in_1 = 5'h04;
    tick();
    n_compared++;
    if (out_result !== 5'h04 || out_valid !== 1'b1) begin
      n_mismatched++;
      $display("FAIL b2b_second: got %h/%b expected 04/1", out_result, out_valid);
    end
`ifdef MUX_5_BIT_PARITY_EN
    n_compared++;
    if (out_parity !== 1'b1) begin
      n_mismatched++;
      $display("FAIL b2b_parity: got %b expected 1", out_parity);
    end
`endif
  endtask

  task automatic test_hold();
    in_valid = 1'b0; in_control = 1'b1; in_0 = 5'h1F; in_1 = 5'h15;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_compared++;
      if (out_result !== 5'h04) begin
        n_mismatched++;
        $display("FAIL hold_result[%0d]: got %h expected 04", i, out_result);
      end
      n_compared++;
      if (out_valid !== 1'b0) begin
        n_mismatched++;
        $display("FAIL hold_valid[%0d]: got %b expected 0", i, out_valid);
      end
    end
  endtask

  task automatic test_equal_inputs();
    in_valid = 1'b1; in_0 = 5'h15; in_1 = 5'h15;
    for (int i = 0; i < 2; i++) begin
      in_control = (i == 0);
      tick();
      n_compared++;
      if (out_result !== 5'h15) begin
        n_mismatched++;
        $display("FAIL equal_inputs[%0d]: got %h expected 15", i, out_result);
      end
    end
  endtask

  task automatic test_no_comb_path();
    in_valid = 1'b1; in_control = 1'b0; in_0 = 5'h06; in_1 = 5'h19;
    tick();
    in_0 = 5'h1E; in_control = 1'b1; in_valid = 1'b0;
    #3;
    n_compared++;
    if (out_result !== 5'h06 || out_valid !== 1'b1) begin
      n_mismatched++;
      $display("FAIL no_comb_path: got %h/%b expected 06/1", out_result, out_valid);
    end
  endtask

  task automatic test_boundary_reset();
    in_valid = 1'b1; in_control = 1'b1; in_0 = 5'h00; in_1 = 5'h1F;
    tick();
    n_compared++;
    if (out_result !== 5'h1F) begin
      n_mismatched++;
      $display("FAIL boundary_1f: got %h expected 1f", out_result);
    end
`ifdef MUX_5_BIT_PARITY_EN
    n_compared++;
    if (out_parity !== 1'b1) begin
      n_mismatched++;
      $display("FAIL boundary_parity: got %b expected 1", out_parity);
    end
`endif
    rst_n = 1'b0;
    tick();
    n_compared++;
    if (out_result !== 5'h00 || out_valid !== 1'b0) begin
      n_mismatched++;
      $display("FAIL midreset: got %h/%b expected 00/0", out_result, out_valid);
    end
    rst_n = 1'b1; in_control = 1'b0; in_0 = 5'h10;
    tick();
    n_compared++;
    if (out_result !== 5'h10 || out_valid !== 1'b1) begin
      n_mismatched++;
      $display("FAIL after_reset: got %h/%b expected 10/1", out_result, out_valid);
    end
  endtask

  task automatic test_unknown_select();
    logic [4:0] exp_val;
    in_valid = 1'b1; in_0 = 5'h07; in_1 = 5'h18;
    in_control = 1'bx;
    // A 2-state simulator resolves the X to some definite level; only a true 1 may pick in_1.
    exp_val = (in_control === 1'b1) ? 5'h18 : 5'h07;
    tick();
    n_compared++;
    if (out_result !== exp_val) begin
      n_mismatched++;
      $display("FAIL unknown_select: got %h expected %h", out_result, exp_val);
    end
  endtask

  initial begin
    n_compared = 0;
    n_mismatched = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_control = 1'b0; in_0 = '0; in_1 = '0;
    @(negedge clk);
    test_reset();
    test_select();
    test_back_to_back();
    test_hold();
    test_equal_inputs();
    test_no_comb_path();
    test_boundary_reset();
    test_unknown_select();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
